// File: rtl/data_mem_mmio_pkg.sv
// Shared address map, timer control bit positions and UART state encoding
// for the data_mem_mmio memory stage.
package data_mem_mmio_pkg;

  localparam logic [8:0] MMIO_BASE = 9'h1F0;

  localparam logic [3:0] OFF_GPIO_OUT  = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN   = 4'h1;
  localparam logic [3:0] OFF_TIMER_CNT = 4'h2;
  localparam logic [3:0] OFF_TIMER_CMP = 4'h3;
  localparam logic [3:0] OFF_TIMER_CTL = 4'h4;
  localparam logic [3:0] OFF_UART_DATA = 4'h5;
  localparam logic [3:0] OFF_UART_STAT = 4'h6;

  localparam int TIMER_CTL_EN   = 0;
  localparam int TIMER_CTL_PEND = 1;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // The peripheral window is the top 16 words of the 9-bit address space.
  function automatic logic is_mmio(input logic [8:0] addr);
    return addr[8:4] == MMIO_BASE[8:4];
  endfunction

endpackage

// File: rtl/data_mem_mmio_uart_tx_byte.sv
// Byte-wide 8N1 UART transmitter: START, 8 data bits LSB first, STOP.
// The FSM state is exported so the parent and checkers can observe it.
module data_mem_mmio_uart_tx_byte
  import data_mem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        tx,
  output uart_state_t state
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Handshake: start is accepted only in a cycle where state==UART_IDLE;
  // busy and the start bit appear on the following cycle, and start is
  // ignored while any other state is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          baud_cnt <= '0;
          if (start) begin
            shreg <= data_in;
            state <= UART_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        UART_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= UART_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= UART_STOP;
            end else begin
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= UART_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus GPIO, compare timer and optional UART
// in the 0x1F0 window. Define MMIO_UART_EN to build the UART transmitter.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 496,
  parameter int CLKS_PER_BIT = 16,
  parameter int GPIO_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_write_en,
  input  logic [8:0]        data_rom_addr,
  input  logic [15:0]       data_rom_in,
  output logic [15:0]       data_rom_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              uart_tx
);

  localparam logic [8:0] RAM_LAST = 9'(RAM_WORDS - 1);

  logic [15:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;
  logic [15:0]       timer_cnt, timer_cmp;
  logic              timer_en, timer_pend, timer_hit;

  logic       in_ram, mmio_sel, wr_ram, wr_mmio;
  logic [3:0] mmio_off;

  assign in_ram   = (data_rom_addr <= RAM_LAST);
  assign mmio_sel = is_mmio(data_rom_addr) && !in_ram;
  assign mmio_off = data_rom_addr[3:0];
  assign wr_ram   = data_write_en && in_ram;
  assign wr_mmio  = data_write_en && mmio_sel;

  always_ff @(posedge clk) begin
    if (wr_ram) ram[data_rom_addr] <= data_rom_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (wr_mmio && mmio_off == OFF_GPIO_OUT) gpio_out <= data_rom_in[GPIO_W-1:0];
    end
  end

  assign timer_hit = timer_en && (timer_cnt == timer_cmp);

  // A compare hit in the same cycle as a PEND clear keeps PEND set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_cnt  <= '0;
      timer_cmp  <= 16'hFFFF;
      timer_en   <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (timer_hit)     timer_cnt <= '0;
      else if (timer_en) timer_cnt <= timer_cnt + 16'd1;
      if (wr_mmio && mmio_off == OFF_TIMER_CMP) timer_cmp <= data_rom_in;
      if (wr_mmio && mmio_off == OFF_TIMER_CTL) timer_en <= data_rom_in[TIMER_CTL_EN];
      if (timer_hit) timer_pend <= 1'b1;
      else if (wr_mmio && mmio_off == OFF_TIMER_CTL && data_rom_in[TIMER_CTL_PEND])
        timer_pend <= 1'b0;
    end
  end

  assign timer_irq = timer_pend;

`ifdef MMIO_UART_EN
  uart_state_t uart_state;
  logic        uart_busy, uart_start;

  assign uart_start = wr_mmio && (mmio_off == OFF_UART_DATA) && (uart_state == UART_IDLE);

  data_mem_mmio_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (uart_start),
    .data_in (data_rom_in[7:0]),
    .busy    (uart_busy),
    .tx      (uart_tx),
    .state   (uart_state)
  );
`else
  assign uart_tx = 1'b1;
`endif

  always_comb begin
    data_rom_read = '0;
    if (in_ram) begin
      data_rom_read = ram[data_rom_addr];
    end else if (mmio_sel) begin
      case (mmio_off)
        OFF_GPIO_OUT:  data_rom_read = 16'(gpio_out);
        OFF_GPIO_IN:   data_rom_read = 16'(gpio_sync2);
        OFF_TIMER_CNT: data_rom_read = timer_cnt;
        OFF_TIMER_CMP: data_rom_read = timer_cmp;
        OFF_TIMER_CTL: begin
          data_rom_read[TIMER_CTL_EN]   = timer_en;
          data_rom_read[TIMER_CTL_PEND] = timer_pend;
        end
`ifdef MMIO_UART_EN
        OFF_UART_STAT: data_rom_read[0] = uart_busy;
`endif
        default: data_rom_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: driver tasks push expected values into a
// scoreboard queue and a negedge monitor pops and compares them.
module tb_data_mem_mmio;

  localparam int K_RD   = 0;
  localparam int K_GPIO = 1;
  localparam int K_IRQ  = 2;
  localparam int K_TX   = 3;

  localparam logic [8:0] A_GPIO_OUT  = 9'h1F0;
  localparam logic [8:0] A_GPIO_IN   = 9'h1F1;
  localparam logic [8:0] A_TIMER_CNT = 9'h1F2;
  localparam logic [8:0] A_TIMER_CMP = 9'h1F3;
  localparam logic [8:0] A_TIMER_CTL = 9'h1F4;
  localparam logic [8:0] A_UART_DATA = 9'h1F5;
  localparam logic [8:0] A_UART_STAT = 9'h1F6;

  logic        clk;
  logic        rst_n;
  logic        data_write_en;
  logic [8:0]  data_rom_addr;
  logic [15:0] data_rom_in;
  logic [15:0] data_rom_read;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;
  logic        uart_tx;

  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  data_mem_mmio #(
    .RAM_WORDS    (496),
    .CLKS_PER_BIT (4),
    .GPIO_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_write_en (data_write_en),
    .data_rom_addr (data_rom_addr),
    .data_rom_in   (data_rom_in),
    .data_rom_read (data_rom_read),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .timer_irq     (timer_irq),
    .uart_tx       (uart_tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [15:0] e, a;
    int          k;
    string       n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_RD:    a = data_rom_read;
        K_GPIO:  a = gpio_out;
        K_IRQ:   a = {15'b0, timer_irq};
        default: a = {15'b0, uart_tx};
      endcase
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
    end
  end

  // driver tasks
  task automatic expect_val(input int kind, input logic [15:0] e, input string name);
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [8:0] a, input logic [15:0] d);
    data_write_en = 1'b1;
    data_rom_addr = a;
    data_rom_in   = d;
    tick();
    data_write_en = 1'b0;
  endtask

  task automatic check_rd(input logic [8:0] a, input logic [15:0] e, input string name);
    data_rom_addr = a;
    expect_val(K_RD, e, name);
    settle();
  endtask

  logic [9:0] frame;

  initial begin
    rst_n = 1'b0;
    data_write_en = 1'b0;
    data_rom_addr = '0;
    data_rom_in = '0;
    gpio_in = '0;
    frame = {1'b1, 8'h55, 1'b0};

    // reset state
    expect_val(K_GPIO, 16'h0000, "reset_gpio_out");
    expect_val(K_IRQ,  16'h0000, "reset_irq");
    expect_val(K_TX,   16'h0001, "reset_uart_tx");
    check_rd(A_TIMER_CMP, 16'hFFFF, "reset_timer_cmp");
    check_rd(A_TIMER_CTL, 16'h0000, "reset_timer_ctl");
    check_rd(A_TIMER_CNT, 16'h0000, "reset_timer_cnt");
    tick();
    rst_n = 1'b1;
    tick();

    // RAM
    store(9'h005, 16'hBEEF);
    check_rd(9'h005, 16'hBEEF, "ram_0x005");
    store(9'h1EF, 16'h1234);
    check_rd(9'h1EF, 16'h1234, "ram_0x1ef");
    check_rd(9'h1FF, 16'h0000, "unmapped_0x1ff");
    store(9'h006, 16'hAAAA);
    data_write_en = 1'b1;
    data_rom_in = 16'h5555;
    expect_val(K_RD, 16'hAAAA, "ram_read_during_write_old");
    settle();
    tick();
    data_write_en = 1'b0;
    check_rd(9'h006, 16'h5555, "ram_after_write");
    store(9'h1F8, 16'hFFFF);
    check_rd(9'h1F8, 16'h0000, "unmapped_0x1f8_write_ignored");
    check_rd(A_UART_DATA, 16'h0000, "uart_data_reads_zero");

    // GPIO
    store(A_GPIO_OUT, 16'h00A5);
    expect_val(K_GPIO, 16'h00A5, "gpio_out");
    check_rd(A_GPIO_OUT, 16'h00A5, "gpio_out_readback");
    tick();
    gpio_in = 16'h3C00;
    check_rd(A_GPIO_IN, 16'h0000, "gpio_in_same_cycle");
    tick();
    check_rd(A_GPIO_IN, 16'h0000, "gpio_in_one_cycle");
    tick();
    check_rd(A_GPIO_IN, 16'h3C00, "gpio_in_two_cycles");

    // timer compare and wrap
    store(A_TIMER_CMP, 16'h0004);
    store(A_TIMER_CTL, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      data_rom_addr = A_TIMER_CNT;
      expect_val(K_RD, (i == 5) ? 16'h0000 : 16'(i), "timer_cnt_seq");
      expect_val(K_IRQ, (i == 5) ? 16'h0001 : 16'h0000, "timer_irq_seq");
      settle();
      tick();
    end
    check_rd(A_TIMER_CTL, 16'h0003, "timer_ctl_en_pend");
    store(A_TIMER_CTL, 16'h0002);
    expect_val(K_IRQ, 16'h0000, "timer_irq_cleared");
    check_rd(A_TIMER_CNT, 16'h0002, "timer_cnt_after_disable");
    tick();
    check_rd(A_TIMER_CNT, 16'h0002, "timer_cnt_holds");
    store(A_TIMER_CTL, 16'h0001);
    tick();
    tick();
    check_rd(A_TIMER_CNT, 16'h0004, "timer_cnt_at_cmp");
    store(A_TIMER_CTL, 16'h0003);
    expect_val(K_IRQ, 16'h0001, "timer_set_wins_over_clear");
    check_rd(A_TIMER_CNT, 16'h0000, "timer_cnt_wrapped");
    store(A_TIMER_CTL, 16'h0000);
    expect_val(K_IRQ, 16'h0001, "timer_pend_kept_on_zero_write");
    check_rd(A_TIMER_CTL, 16'h0002, "timer_ctl_pend_only");

`ifdef MMIO_UART_EN
    // UART frame with a dropped second write
    store(A_UART_DATA, 16'h0155);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        data_write_en = 1'b1;
        data_rom_addr = A_UART_DATA;
        data_rom_in = 16'h00FF;
      end else begin
        data_write_en = 1'b0;
        data_rom_addr = A_UART_STAT;
        expect_val(K_RD, 16'h0001, "uart_busy");
      end
      expect_val(K_TX, {15'b0, frame[k / 4]}, "uart_tx_bit");
      settle();
      tick();
    end
    data_write_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      data_rom_addr = A_UART_STAT;
      expect_val(K_RD, 16'h0000, "uart_idle_after_frame");
      expect_val(K_TX, 16'h0001, "uart_tx_idle_high");
      settle();
      tick();
    end
    store(A_UART_DATA, 16'h00A5);
    expect_val(K_TX, 16'h0000, "uart_start_bit_before_reset");
    settle();
    tick();
`else
    // UART absent: window is unmapped and the line stays high
    store(A_UART_DATA, 16'h0155);
    for (int k = 0; k < 20; k++) begin
      data_rom_addr = A_UART_STAT;
      expect_val(K_RD, 16'h0000, "uart_stat_unmapped");
      expect_val(K_TX, 16'h0001, "uart_tx_tied_high");
      settle();
      tick();
    end
`endif

    // asynchronous reset mid-frame with irq pending
    expect_val(K_IRQ, 16'h0001, "irq_before_reset");
    expect_val(K_GPIO, 16'h00A5, "gpio_before_reset");
    settle();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect_val(K_TX,   16'h0001, "async_reset_uart_tx");
    expect_val(K_IRQ,  16'h0000, "async_reset_irq");
    expect_val(K_GPIO, 16'h0000, "async_reset_gpio_out");
    settle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_rd(9'h005, 16'hBEEF, "ram_survives_reset");
    check_rd(A_TIMER_CMP, 16'hFFFF, "timer_cmp_after_reset");
    expect_val(K_TX, 16'h0001, "uart_tx_after_reset");
    settle();
    tick();

    settle();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
